gen_width_adapter: RTL and testbench
====================================

# gen_width_adapter

Multi-channel, pipelined width adapter for fixed-point sample streams. Each channel is sign- or zero-extended when widening, or clamped with saturation when narrowing, from IN_WIDTH to OUT_WIDTH bits. A valid/ready handshake with a two-entry skid buffer provides full throughput under backpressure. It sits between ADC/sensor sample paths and the wider accumulation/gradient datapath.

## Interface
- IN_WIDTH, 12, input sample width per channel (>=2)
- OUT_WIDTH, 32, output sample width per channel (>=2; may be <, =, > IN_WIDTH)
- CHANNELS, 4, number of parallel channels (>=1)
- SAT_CNT_WIDTH, 16, width of saturation event counter

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_data  in  CHANNELS*IN_WIDTH  channel k at bits [k*IN_WIDTH +: IN_WIDTH]
- in_signed  in  1  1 = two's complement, 0 = unsigned; sampled with each accepted beat
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- out_data  out  CHANNELS*OUT_WIDTH  channel k at bits [k*OUT_WIDTH +: OUT_WIDTH]
- out_sat  out  CHANNELS  per-channel saturation flag for the current output beat
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- sat_clr  in  1  clears sat_count
- sat_count  out  SAT_CNT_WIDTH  accepted beats with any out_sat bit set

## Operation
- Per channel, with mode taken from in_signed:
  - OUT_WIDTH >= IN_WIDTH, signed: replicate the input MSB into the upper OUT_WIDTH-IN_WIDTH bits.
  - OUT_WIDTH >= IN_WIDTH, unsigned: zero-fill the upper bits.
  - In both widening cases out_sat = 0.
  - OUT_WIDTH < IN_WIDTH, signed: clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. out_sat=1 iff clamped.
  - OUT_WIDTH < IN_WIDTH, unsigned: clamp to 2^OUT_WIDTH-1. out_sat=1 iff clamped.
  - Otherwise the output is the low OUT_WIDTH bits.
- Conversion is combinational into the output stage. The result and its out_sat bits travel together through the pipeline.
- Storage: output register (O) and skid register (S). States are EMPTY (O,S empty), ONE (O full), FULL (O,S full).
  - EMPTY: on accept, go to ONE.
  - ONE: out_ready with no accept, go to EMPTY. Accept with out_ready low, go to FULL (beat into S). Accept with out_ready high, stay ONE (O reloaded).
  - FULL: on out_ready, S moves to O, go to ONE. No accept is possible in FULL.
- in_ready = (state != FULL). This is a registered output.
- Beat order is strictly preserved. No beat is dropped or duplicated.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is on out_data/out_valid after edge N.
- Throughput is 1 beat/cycle while out_ready stays high.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- out_data/out_sat are stable while out_valid=1 and out_ready=0.
- Reset (rst_n low at an edge) sets: state EMPTY, out_valid=0, in_ready=1, out_data=0, out_sat=0, sat_count=0.
  - Reset mid-operation discards O and S contents.
  - Reset overrides all simultaneous events.
- in_ready is 0 during reset and 1 from the first edge after reset deasserts.
- sat_count increments by 1 on each accepted beat producing any out_sat bit. It sticks at all-ones (no wrap).
- sat_clr has priority over a same-cycle increment: the result is 0.

## Configuration
- GEN_WIDTH_ADAPTER_SAT_CNT_EN:
  - Defined: sat_count and sat_clr function as above.
  - Undefined: the counter logic is not built, sat_count is tied to 0 and sat_clr is ignored. Port list is unchanged; datapath and out_sat are unaffected.

## Test plan
- IN=12, OUT=32, in_signed=1: in 0x800, 0x7FF -> out 0xFFFFF800, 0x000007FF; out_sat=0; 1-cycle latency.
- IN=12, OUT=32, in_signed=0: in 0x800 -> 0x00000800.
- IN=16, OUT=8, signed: in 0x7FFF, 0x8000, 0xFF80, 0x0005 -> out 0x7F, 0x80, 0x80, 0x05 with out_sat 1, 1, 0, 0.
- IN=16, OUT=8, unsigned: in 0x0100 -> 0xFF with out_sat=1. Over 3 such beats sat_count reaches 3, then sat_clr gives 0. With SAT_CNT_WIDTH=2 and 5 saturating beats, sat_count holds at 3.
- Backpressure, CHANNELS=4: hold out_ready=0 and offer beats A, B, C back-to-back.
  - A is held in O and B in S; in_ready drops after B, so C is stalled.
  - Release out_ready: output order is A, B, C, with C accepted one cycle after release.
- Reset mid-stream in the FULL state: pulse rst_n=0 for one edge. Then out_valid=0, in_ready=1 and sat_count=0, and the next beat appears alone with 1-cycle latency.

Source files
------------

// File: rtl/gen_width_adapter_if.sv
// Sample-stream bundle for gen_width_adapter: input beat side and output beat side.
// master drives beats in and consumes beats out; slave is the adapter's view.
interface gen_width_adapter_if #(
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 32,
    parameter int CHANNELS  = 4
) ();
    logic [CHANNELS*IN_WIDTH-1:0]  in_data;
    logic                          in_signed;
    logic                          in_valid;
    logic                          in_ready;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data;
    logic [CHANNELS-1:0]           out_sat;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        output in_data, in_signed, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );

    modport slave (
        input  in_data, in_signed, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/gen_width_adapter.sv
// Per-channel sign/zero-extend or saturating narrow, 1-cycle latency, 2-entry skid for full-rate backpressure.
// Saturation event counter built only with GEN_WIDTH_ADAPTER_SAT_CNT_EN defined; otherwise sat_count reads 0.
module gen_width_adapter #(
    parameter int IN_WIDTH      = 12,
    parameter int OUT_WIDTH     = 32,
    parameter int CHANNELS      = 4,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gen_width_adapter_if.slave       bus,
    input  logic                     sat_clr,
    output logic [SAT_CNT_WIDTH-1:0] sat_count
);
    localparam int OW = CHANNELS * OUT_WIDTH;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       o_dat_q, o_dat_d, s_dat_q, s_dat_d, cv_dat;
    logic [CHANNELS-1:0] o_sat_q, o_sat_d, s_sat_q, s_sat_d, cv_sat;
    logic                in_rdy_q;
    logic                acc;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [IN_WIDTH-1:0]  x;
        logic [OUT_WIDTH-1:0] y;
        logic                 s;

        assign x = bus.in_data[k*IN_WIDTH +: IN_WIDTH];

        if (OUT_WIDTH > IN_WIDTH) begin : g_wide
            assign y = {{(OUT_WIDTH-IN_WIDTH){bus.in_signed & x[IN_WIDTH-1]}}, x};
            assign s = 1'b0;
        end else if (OUT_WIDTH == IN_WIDTH) begin : g_same
            assign y = x;
            assign s = 1'b0;
        end else begin : g_narrow
            // A signed value fits when every dropped bit equals the new sign bit.
            logic fits_s, fits_u;
            assign fits_s = (x[IN_WIDTH-1:OUT_WIDTH-1] == {(IN_WIDTH-OUT_WIDTH+1){x[IN_WIDTH-1]}});
            assign fits_u = ~|x[IN_WIDTH-1:OUT_WIDTH];

            always_comb begin
                y = x[OUT_WIDTH-1:0];
                s = 1'b0;
                if (bus.in_signed && !fits_s) begin
                    s = 1'b1;
                    y = x[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
                end else if (!bus.in_signed && !fits_u) begin
                    s = 1'b1;
                    y = '1;
                end
            end
        end

        assign cv_dat[k*OUT_WIDTH +: OUT_WIDTH] = y;
        assign cv_sat[k]                        = s;
    end

    assign acc           = bus.in_valid & in_rdy_q;
    assign bus.in_ready  = in_rdy_q & rst_n;
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.out_data  = o_dat_q;
    assign bus.out_sat   = o_sat_q;

    always_comb begin
        state_d = state_q;
        o_dat_d = o_dat_q;
        o_sat_d = o_sat_q;
        s_dat_d = s_dat_q;
        s_sat_d = s_sat_q;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d = ONE;
                    o_dat_d = cv_dat;
                    o_sat_d = cv_sat;
                end
            end
            ONE: begin
                if (acc && bus.out_ready) begin
                    o_dat_d = cv_dat;
                    o_sat_d = cv_sat;
                end else if (acc) begin
                    state_d = FULL;
                    s_dat_d = cv_dat;
                    s_sat_d = cv_sat;
                end else if (bus.out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    state_d = ONE;
                    o_dat_d = s_dat_q;
                    o_sat_d = s_sat_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            o_dat_q  <= '0;
            o_sat_q  <= '0;
            s_dat_q  <= '0;
            s_sat_q  <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            o_dat_q  <= o_dat_d;
            o_sat_q  <= o_sat_d;
            s_dat_q  <= s_dat_d;
            s_sat_q  <= s_sat_d;
            in_rdy_q <= (state_d != FULL);
        end
    end

`ifdef GEN_WIDTH_ADAPTER_SAT_CNT_EN
    logic [SAT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle event; the count parks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (sat_clr) begin
            cnt_d = '0;
        end else if (acc && (|cv_sat) && !(&cnt_q)) begin
            cnt_d = cnt_q + SAT_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`else
    logic unused_sat_clr;
    assign unused_sat_clr = sat_clr;
    assign sat_count      = '0;
`endif
endmodule

// File: tb/tb_gen_width_adapter.sv
// Bench for gen_width_adapter: a widening 12->32 instance and a narrowing 16->8 instance (2-bit counter).
// Table vectors, hand-written backpressure/reset/counter sequences, and a randomized queue-model run.
module tb_gen_width_adapter;
`ifdef GEN_WIDTH_ADAPTER_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sat_clr_w, sat_clr_n;
    logic [15:0] cnt_w_o;
    logic [1:0]  cnt_n_o;

    always #5 clk = ~clk;

    gen_width_adapter_if #(.IN_WIDTH(12), .OUT_WIDTH(32), .CHANNELS(4)) w ();
    gen_width_adapter_if #(.IN_WIDTH(16), .OUT_WIDTH(8),  .CHANNELS(4)) n ();

    gen_width_adapter #(.IN_WIDTH(12), .OUT_WIDTH(32), .CHANNELS(4), .SAT_CNT_WIDTH(16)) u_w (
        .clk(clk), .rst_n(rst_n), .bus(w), .sat_clr(sat_clr_w), .sat_count(cnt_w_o));
    gen_width_adapter #(.IN_WIDTH(16), .OUT_WIDTH(8), .CHANNELS(4), .SAT_CNT_WIDTH(2)) u_n (
        .clk(clk), .rst_n(rst_n), .bus(n), .sat_clr(sat_clr_n), .sat_count(cnt_n_o));

    typedef struct {logic [127:0] d; logic [3:0] s;} beat_w_t;
    typedef struct {logic [31:0] d;  logic [3:0] s;} beat_n_t;
    typedef struct {logic sgn; logic [11:0] x; logic [31:0] y;} vec_w_t;
    typedef struct {logic sgn; logic [15:0] x; logic [7:0] y; logic s;} vec_n_t;

    beat_w_t qw[$];
    beat_n_t qn[$];
    int      cnt_w, cnt_n;
    int      checks = 0;
    int      failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] conv_w(input logic [11:0] x, input logic sgn);
        int v;
        v = int'(x);
        if (sgn && x >= 12'd2048) v = v - 4096;
        return v;
    endfunction

    function automatic void conv_n(input logic [15:0] x, input logic sgn,
                                   output logic [7:0] y, output logic s);
        int v, lo, hi;
        v  = int'(x);
        if (sgn && x >= 16'd32768) v = v - 65536;
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        s  = (v < lo) || (v > hi);
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        y  = v[7:0];
    endfunction

    function automatic beat_w_t build_w(input logic [47:0] d, input logic sgn);
        beat_w_t b;
        for (int k = 0; k < 4; k++) b.d[k*32 +: 32] = conv_w(d[k*12 +: 12], sgn);
        b.s = '0;
        return b;
    endfunction

    function automatic beat_n_t build_n(input logic [63:0] d, input logic sgn);
        beat_n_t b;
        logic [7:0] y;
        logic       s;
        for (int k = 0; k < 4; k++) begin
            conv_n(d[k*16 +: 16], sgn, y, s);
            b.d[k*8 +: 8] = y;
            b.s[k]        = s;
        end
        return b;
    endfunction

    function automatic int next_cnt(input int c, input logic clr, input logic inc, input int max);
        if (!CNT_EN) return 0;
        if (clr) return 0;
        if (inc && c < max) return c + 1;
        return c;
    endfunction

    // One clock: predict handshakes from the model, advance it, then compare every output.
    task automatic cycle();
        logic    rst_now, acc_w, acc_n, xf_w, xf_n, clr_w, clr_n;
        beat_w_t bw;
        beat_n_t bn;
        rst_now = rst_n;
        bw      = build_w(w.in_data, w.in_signed);
        bn      = build_n(n.in_data, n.in_signed);
        acc_w   = rst_now && w.in_valid && (qw.size() < 2);
        acc_n   = rst_now && n.in_valid && (qn.size() < 2);
        xf_w    = rst_now && w.out_ready && (qw.size() > 0);
        xf_n    = rst_now && n.out_ready && (qn.size() > 0);
        clr_w   = sat_clr_w;
        clr_n   = sat_clr_n;
        @(posedge clk);
        #1;
        if (!rst_now) begin
            qw.delete();
            qn.delete();
            cnt_w = 0;
            cnt_n = 0;
        end else begin
            if (xf_w) void'(qw.pop_front());
            if (acc_w) qw.push_back(bw);
            if (xf_n) void'(qn.pop_front());
            if (acc_n) qn.push_back(bn);
            cnt_w = next_cnt(cnt_w, clr_w, acc_w && (|bw.s), 65535);
            cnt_n = next_cnt(cnt_n, clr_n, acc_n && (|bn.s), 3);
        end
        chk("w_out_valid", w.out_valid, qw.size() > 0);
        chk("w_in_ready", w.in_ready, rst_now && (qw.size() < 2));
        chk("n_out_valid", n.out_valid, qn.size() > 0);
        chk("n_in_ready", n.in_ready, rst_now && (qn.size() < 2));
        if (qw.size() > 0) begin
            chk("w_out_data", w.out_data, qw[0].d);
            chk("w_out_sat", w.out_sat, qw[0].s);
        end
        if (qn.size() > 0) begin
            chk("n_out_data", n.out_data, qn[0].d);
            chk("n_out_sat", n.out_sat, qn[0].s);
        end
        chk("w_sat_count", cnt_w_o, cnt_w);
        chk("n_sat_count", cnt_n_o, cnt_n);
    endtask

    vec_w_t      tw[5];
    vec_n_t      tn[9];
    logic [15:0] edge_vals[10];
    logic [47:0] a_in, b_in, c_in;
    logic [127:0] a_out, b_out, c_out;

    initial begin
        tw[0] = '{1'b1, 12'h800, 32'hFFFFF800};
        tw[1] = '{1'b1, 12'h7FF, 32'h000007FF};
        tw[2] = '{1'b0, 12'h800, 32'h00000800};
        tw[3] = '{1'b0, 12'hFFF, 32'h00000FFF};
        tw[4] = '{1'b1, 12'hFFF, 32'hFFFFFFFF};
        tn[0] = '{1'b1, 16'h7FFF, 8'h7F, 1'b1};
        tn[1] = '{1'b1, 16'h8000, 8'h80, 1'b1};
        tn[2] = '{1'b1, 16'hFF80, 8'h80, 1'b0};
        tn[3] = '{1'b1, 16'h0005, 8'h05, 1'b0};
        tn[4] = '{1'b0, 16'h0100, 8'hFF, 1'b1};
        tn[5] = '{1'b0, 16'h00FF, 8'hFF, 1'b0};
        tn[6] = '{1'b1, 16'hFF7F, 8'h80, 1'b1};
        tn[7] = '{1'b1, 16'h007F, 8'h7F, 1'b0};
        tn[8] = '{1'b1, 16'h0080, 8'h7F, 1'b1};
        edge_vals = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h00FF,
                      16'h0100, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        a_in  = {12'h004, 12'h003, 12'h002, 12'h001};
        a_out = {32'h4, 32'h3, 32'h2, 32'h1};
        b_in  = {12'hFFF, 12'h800, 12'h7FF, 12'h123};
        b_out = {32'hFFFFFFFF, 32'hFFFFF800, 32'h000007FF, 32'h00000123};
        c_in  = {12'hABC, 12'h0F0, 12'h00F, 12'h800};
        c_out = {32'h00000ABC, 32'h000000F0, 32'h0000000F, 32'h00000800};
        cnt_w = 0;
        cnt_n = 0;

        rst_n = 1'b0;
        sat_clr_w = 1'b0; sat_clr_n = 1'b0;
        w.in_data = '0; w.in_signed = 1'b0; w.in_valid = 1'b0; w.out_ready = 1'b0;
        n.in_data = '0; n.in_signed = 1'b0; n.in_valid = 1'b0; n.out_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_w_out_data", w.out_data, '0);
        chk("rst_n_out_data", n.out_data, '0);
        chk("rst_n_out_sat", n.out_sat, '0);
        chk("rst_in_ready_low", w.in_ready, 1'b0);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_in_ready", w.in_ready, 1'b1);

        // Table vectors: one beat per entry, empty pipe, downstream always ready.
        w.out_ready = 1'b1;
        n.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w.in_signed = tw[i].sgn;
            w.in_data   = {4{tw[i].x}};
            w.in_valid  = 1'b1;
            cycle();
            chk($sformatf("tw%0d_valid", i), w.out_valid, 1'b1);
            chk($sformatf("tw%0d_data", i), w.out_data, {4{tw[i].y}});
            chk($sformatf("tw%0d_sat", i), w.out_sat, 4'b0);
        end
        w.in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n.in_signed = tn[i].sgn;
            n.in_data   = {4{tn[i].x}};
            n.in_valid  = 1'b1;
            cycle();
            chk($sformatf("tn%0d_data", i), n.out_data, {4{tn[i].y}});
            chk($sformatf("tn%0d_sat", i), n.out_sat, {4{tn[i].s}});
        end
        n.in_valid = 1'b0;
        cycle();

        // Saturation counter: count, clear, stick at all-ones, clear beats increment.
        sat_clr_n = 1'b1;
        cycle();
        sat_clr_n = 1'b0;
        chk("cnt_cleared", cnt_n_o, 2'd0);
        n.in_signed = 1'b0;
        n.in_data   = {4{16'h0100}};
        n.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk($sformatf("cnt_up%0d", i), cnt_n_o, CNT_EN ? 2'(i + 1) : 2'd0);
        end
        n.in_valid = 1'b0;
        sat_clr_n  = 1'b1;
        cycle();
        sat_clr_n  = 1'b0;
        chk("cnt_clr", cnt_n_o, 2'd0);
        n.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk($sformatf("cnt_hold%0d", i), cnt_n_o, CNT_EN ? 2'((i < 3) ? i + 1 : 3) : 2'd0);
        end
        sat_clr_n = 1'b1;
        cycle();
        sat_clr_n = 1'b0;
        chk("cnt_clr_priority", cnt_n_o, 2'd0);
        n.in_valid = 1'b0;
        cycle();

        // Backpressure: A in O, B in S, C stalled until one cycle after release.
        w.out_ready = 1'b0;
        w.in_valid  = 1'b1;
        w.in_signed = 1'b0;
        w.in_data   = a_in;
        cycle();
        chk("bp_A_out", w.out_data, a_out);
        w.in_signed = 1'b1;
        w.in_data   = b_in;
        cycle();
        chk("bp_full_in_ready", w.in_ready, 1'b0);
        chk("bp_A_held", w.out_data, a_out);
        w.in_signed = 1'b0;
        w.in_data   = c_in;
        cycle();
        chk("bp_A_stable", w.out_data, a_out);
        w.out_ready = 1'b1;
        cycle();
        chk("bp_B_out", w.out_data, b_out);
        chk("bp_ready_back", w.in_ready, 1'b1);
        cycle();
        chk("bp_C_out", w.out_data, c_out);
        w.in_valid = 1'b0;
        cycle();
        chk("bp_drained", w.out_valid, 1'b0);

        // Reset while both instances are FULL.
        w.out_ready = 1'b0;
        n.out_ready = 1'b0;
        w.in_valid  = 1'b1;
        n.in_valid  = 1'b1;
        n.in_signed = 1'b0;
        n.in_data   = {4{16'h0100}};
        w.in_data   = b_in;
        w.in_signed = 1'b1;
        cycle();
        w.in_data = c_in;
        cycle();
        chk("full_before_rst", w.in_ready, 1'b0);
        w.in_valid = 1'b0;
        n.in_valid = 1'b0;
        rst_n      = 1'b0;
        cycle();
        chk("rst_mid_valid", w.out_valid, 1'b0);
        chk("rst_mid_cnt", cnt_n_o, 2'd0);
        rst_n = 1'b1;
        cycle();
        chk("rst_mid_in_ready", w.in_ready, 1'b1);
        w.in_valid  = 1'b1;
        w.in_signed = 1'b0;
        w.in_data   = a_in;
        w.out_ready = 1'b1;
        n.out_ready = 1'b1;
        cycle();
        chk("rst_next_beat", w.out_data, a_out);
        w.in_valid = 1'b0;
        cycle();
        chk("rst_beat_alone", w.out_valid, 1'b0);

        // Randomized traffic against the queue model.
        for (int c = 0; c < 800; c++) begin
            w.in_valid  = ($urandom_range(0, 9) < 7);
            w.out_ready = ($urandom_range(0, 9) < 6);
            w.in_signed = 1'($urandom_range(0, 1));
            w.in_data   = {$urandom(), 16'($urandom())};
            sat_clr_w   = ($urandom_range(0, 19) == 0);
            n.in_valid  = ($urandom_range(0, 9) < 7);
            n.out_ready = ($urandom_range(0, 9) < 6);
            n.in_signed = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                n.in_data[k*16 +: 16] = ($urandom_range(0, 1) == 0) ? 16'($urandom())
                                        : edge_vals[$urandom_range(0, 9)];
            end
            sat_clr_n   = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
